mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sequences the single asynchronous SRAM and shares it between two requesters: the CPU (microsequencer-driven load/store and instruction fetch) and a secondary DMA/debug loader port.
- Owns the SRAM strobes (notCS/notOE/notWE), the address and the write-data drivers.
- Produces setup/strobe/hold phases so address and data are stable around every strobe edge.
- Returns read data and a one-cycle acknowledge to the granted requester.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- WAIT_CYCLES, 1, number of strobe-phase cycles per access; legal range 1..15.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- notReset  in  1  asynchronous, active-low reset.
- cpuReq  in  1  CPU access request; held until cpuAck.
- cpuWrite  in  1  1=write, 0=read; stable while cpuReq is high.
- cpuAddr  in  ADDR_W  CPU address.
- cpuWData  in  DATA_W  CPU write data.
- cpuRData  out  DATA_W  CPU read data, registered.
- cpuAck  out  1  one-cycle completion pulse.
- dmaReq, dmaWrite, dmaAddr, dmaWData, dmaRData, dmaAck: same as the CPU equivalents, for the DMA port.
- grantDma  out  1  1 while a DMA transaction owns the SRAM.
- memAddr  out  ADDR_W  SRAM address.
- memWData  out  DATA_W  SRAM write data.
- memDataOE  out  1  enables memWData onto the SRAM data pins.
- memRData  in  DATA_W  SRAM read data.
- memNotCS  out  1  SRAM chip select, active-low.
- memNotOE  out  1  SRAM output enable, active-low.
- memNotWE  out  1  SRAM write enable, active-low.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state IDLE; memNotCS=memNotOE=memNotWE=1; memDataOE=0; memAddr=0; memWData=0; cpuAck=dmaAck=0; cpuRData=dmaRData=0; grantDma=0.
- Reset mid-transaction: strobes deassert immediately (asynchronously), no ack is issued, and the transaction is dropped.
- All outputs are registered.
- State machine: IDLE -> SETUP -> STROBE (WAIT_CYCLES cycles) -> HOLD -> IDLE.
- IDLE: samples cpuReq/dmaReq and arbitrates. The winner's address, write flag and data are captured into internal registers, and the machine moves to SETUP. With no request it stays in IDLE with all strobes high.
- SETUP (1 cycle): memNotCS=0; memAddr valid; for writes, memDataOE=1 and memWData valid. memNotOE=memNotWE=1.
- STROBE: reads drive memNotOE=0; writes drive memNotWE=0. A down-counter loaded with WAIT_CYCLES-1 counts to 0. memRData is captured on the edge that ends the last STROBE cycle.
- HOLD (1 cycle): memNotOE=memNotWE=1; memNotCS=0; address and write data stay unchanged. The granted port's Ack=1, and its RData holds the captured value (reads only; on writes RData is left unchanged).
- Back in IDLE: strobes high and memDataOE=0.
- Latency (WAIT_CYCLES=1): request seen in IDLE at cycle 0 -> ack in cycle 3 -> next grant possible in cycle 4. Transaction period is WAIT_CYCLES+3 cycles.
- Requester rules:
  - A requester must deassert Req, or present a new request, on the edge where it samples Ack=1.
  - A Req high in IDLE is always treated as a new request.
  - Inputs are ignored outside IDLE.
- RData persistence: RData holds until that port's next read completes.
- Arbitration (default): fixed priority, CPU over DMA. When both request simultaneously, the CPU is served and the DMA waits.
- grantDma: set on entry to SETUP for a DMA grant; cleared on return to IDLE.
- Address and data pass through with no width conversion; memAddr is never changed while memNotCS=0.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- When defined: round-robin arbitration. A last-grant bit, reset to DMA, makes the CPU win the first tie; on each tie the port not granted last time wins. A single requester is always granted.
- When undefined: fixed CPU priority as described above; a continuously requesting CPU can starve the DMA.

Test Plan:
- CPU read, WAIT_CYCLES=1, SRAM[0x0010]=0xBEEF, cpuReq at cycle 0 -> memNotOE low only in cycle 2; cpuAck pulses in cycle 3; cpuRData=0xBEEF; memNotCS low in cycles 1-3.
- DMA write 0x1234 to 0x0020 -> memNotWE low for exactly 1 cycle with memDataOE=1 from SETUP through HOLD; read-back by the CPU returns 0x1234; grantDma high in cycles 1-3.
- Simultaneous cpuReq and dmaReq, both held for two transactions:
  - Default build: CPU, CPU (DMA starved).
  - With MEM_ARB_RR_EN: CPU then DMA; acks are 4 cycles apart.
- WAIT_CYCLES=3 read -> memNotOE low for 3 cycles; ack at cycle 5; no strobe changes while memAddr changes.
- notReset pulsed low during STROBE of a write -> memNotWE/memNotCS go high immediately; no ack; state IDLE; all outputs at reset values.
- cpuReq held high across cpuAck for back-to-back reads of 0x0000 and 0x0001 -> two acks 4 cycles apart with correct data each.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: sequences one asynchronous SRAM for a CPU port and a DMA port (setup/strobe/hold).
// Optional MEM_ARB_RR_EN selects round-robin arbitration instead of fixed CPU priority. Rev 1.0
`default_nettype none

module mem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clock,
  input  logic              notReset,
  input  logic              cpuReq,
  input  logic              cpuWrite,
  input  logic [ADDR_W-1:0] cpuAddr,
  input  logic [DATA_W-1:0] cpuWData,
  output logic [DATA_W-1:0] cpuRData,
  output logic              cpuAck,
  input  logic              dmaReq,
  input  logic              dmaWrite,
  input  logic [ADDR_W-1:0] dmaAddr,
  input  logic [DATA_W-1:0] dmaWData,
  output logic [DATA_W-1:0] dmaRData,
  output logic              dmaAck,
  output logic              grantDma,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWData,
  output logic              memDataOE,
  input  logic [DATA_W-1:0] memRData,
  output logic              memNotCS,
  output logic              memNotOE,
  output logic              memNotWE
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] STROBE = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  logic [1:0] state;
  logic [3:0] wait_cnt;
  logic       is_write;
  logic       pick_dma;
  logic       any_req;

`ifdef MEM_ARB_RR_EN
  logic last_dma;

  // On a tie the port that was not granted last time wins.
  always_comb begin
    pick_dma = dmaReq & (~cpuReq | ~last_dma);
  end

  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      last_dma <= 1'b1;
    end else if (state == IDLE && any_req) begin
      last_dma <= pick_dma;
    end
  end
`else
  always_comb begin
    pick_dma = dmaReq & ~cpuReq;
  end
`endif

  assign any_req = cpuReq | dmaReq;

  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      is_write  <= 1'b0;
      grantDma  <= 1'b0;
      memAddr   <= '0;
      memWData  <= '0;
      memDataOE <= 1'b0;
      memNotCS  <= 1'b1;
      memNotOE  <= 1'b1;
      memNotWE  <= 1'b1;
      cpuAck    <= 1'b0;
      dmaAck    <= 1'b0;
      cpuRData  <= '0;
      dmaRData  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state     <= SETUP;
            grantDma  <= pick_dma;
            memNotCS  <= 1'b0;
            memAddr   <= pick_dma ? dmaAddr : cpuAddr;
            memWData  <= pick_dma ? dmaWData : cpuWData;
            is_write  <= pick_dma ? dmaWrite : cpuWrite;
            memDataOE <= pick_dma ? dmaWrite : cpuWrite;
          end
        end
        SETUP: begin
          state    <= STROBE;
          wait_cnt <= WAIT_LOAD;
          if (is_write) begin
            memNotWE <= 1'b0;
          end else begin
            memNotOE <= 1'b0;
          end
        end
        STROBE: begin
          if (wait_cnt == 4'd0) begin
            // Read data is sampled on the same edge that raises the strobe.
            state    <= HOLD;
            memNotOE <= 1'b1;
            memNotWE <= 1'b1;
            if (grantDma) begin
              dmaAck <= 1'b1;
              if (!is_write) dmaRData <= memRData;
            end else begin
              cpuAck <= 1'b1;
              if (!is_write) cpuRData <= memRData;
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        HOLD: begin
          state     <= IDLE;
          memNotCS  <= 1'b1;
          memDataOE <= 1'b0;
          grantDma  <= 1'b0;
          cpuAck    <= 1'b0;
          dmaAck    <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus hand-written multi-cycle sequences for mem_arbiter.
`default_nettype none

module tb_mem_arbiter;

  logic        clock;
  logic        notReset;
  logic        cpuReq, cpuWrite, dmaReq, dmaWrite;
  logic [15:0] cpuAddr, cpuWData, dmaAddr, dmaWData;
  logic [15:0] cpuRData, dmaRData, memAddr, memWData, memRData;
  logic        cpuAck, dmaAck, grantDma, memDataOE, memNotCS, memNotOE, memNotWE;

  // second instance with a longer strobe, CPU reads only
  logic        w3_cpuReq;
  logic [15:0] w3_cpuAddr, w3_cpuRData, w3_dmaRData, w3_memAddr, w3_memWData, w3_memRData;
  logic        w3_cpuAck, w3_dmaAck, w3_grantDma, w3_memDataOE, w3_memNotCS, w3_memNotOE, w3_memNotWE;

  logic [15:0] sram [0:255];
  logic        load_en;
  logic [7:0]  load_addr;
  logic [15:0] load_data;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_cpu_rd, exp_dma_rd;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(1)) u_dut (
    .clock(clock), .notReset(notReset),
    .cpuReq(cpuReq), .cpuWrite(cpuWrite), .cpuAddr(cpuAddr), .cpuWData(cpuWData),
    .cpuRData(cpuRData), .cpuAck(cpuAck),
    .dmaReq(dmaReq), .dmaWrite(dmaWrite), .dmaAddr(dmaAddr), .dmaWData(dmaWData),
    .dmaRData(dmaRData), .dmaAck(dmaAck), .grantDma(grantDma),
    .memAddr(memAddr), .memWData(memWData), .memDataOE(memDataOE), .memRData(memRData),
    .memNotCS(memNotCS), .memNotOE(memNotOE), .memNotWE(memNotWE)
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(3)) u_dut3 (
    .clock(clock), .notReset(notReset),
    .cpuReq(w3_cpuReq), .cpuWrite(1'b0), .cpuAddr(w3_cpuAddr), .cpuWData(16'h0000),
    .cpuRData(w3_cpuRData), .cpuAck(w3_cpuAck),
    .dmaReq(1'b0), .dmaWrite(1'b0), .dmaAddr(16'h0000), .dmaWData(16'h0000),
    .dmaRData(w3_dmaRData), .dmaAck(w3_dmaAck), .grantDma(w3_grantDma),
    .memAddr(w3_memAddr), .memWData(w3_memWData), .memDataOE(w3_memDataOE), .memRData(w3_memRData),
    .memNotCS(w3_memNotCS), .memNotOE(w3_memNotOE), .memNotWE(w3_memNotWE)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // SRAM model: reads are combinational while selected and output-enabled
  assign memRData    = (!memNotCS && !memNotOE) ? sram[memAddr[7:0]] : 16'hDEAD;
  assign w3_memRData = (!w3_memNotCS && !w3_memNotOE) ? sram[w3_memAddr[7:0]] : 16'hDEAD;

  always @(posedge clock) begin
    if (load_en) sram[load_addr] <= load_data;
    else if (!memNotCS && !memNotWE && memDataOE) sram[memAddr[7:0]] <= memWData;
  end

  typedef struct {
    logic        dma;
    logic        write;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load(input logic [7:0] a, input logic [15:0] d);
    @(negedge clock);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clock);
    load_en = 1'b0;
  endtask

  task automatic run_txn(input int idx, input vec_t v);
    bit in_tx;
    @(posedge clock); #1;
    if (v.dma) begin
      dmaReq = 1'b1; dmaWrite = v.write; dmaAddr = v.addr; dmaWData = v.wdata;
    end else begin
      cpuReq = 1'b1; cpuWrite = v.write; cpuAddr = v.addr; cpuWData = v.wdata;
    end
    for (int c = 0; c <= 5; c++) begin
      @(negedge clock);
      in_tx = (c >= 1 && c <= 3);
      chk($sformatf("v%0d c%0d notCS", idx, c), memNotCS, !in_tx);
      chk($sformatf("v%0d c%0d notOE", idx, c), memNotOE, !(!v.write && c == 2));
      chk($sformatf("v%0d c%0d notWE", idx, c), memNotWE, !(v.write && c == 2));
      chk($sformatf("v%0d c%0d dataOE", idx, c), memDataOE, v.write && in_tx);
      chk($sformatf("v%0d c%0d grantDma", idx, c), grantDma, v.dma && in_tx);
      chk($sformatf("v%0d c%0d cpuAck", idx, c), cpuAck, !v.dma && c == 3);
      chk($sformatf("v%0d c%0d dmaAck", idx, c), dmaAck, v.dma && c == 3);
      if (in_tx) chk($sformatf("v%0d c%0d memAddr", idx, c), memAddr, v.addr);
      if (in_tx && v.write) chk($sformatf("v%0d c%0d memWData", idx, c), memWData, v.wdata);
      if (c == 3) begin
        if (!v.write) begin
          if (v.dma) exp_dma_rd = v.exp_rdata;
          else       exp_cpu_rd = v.exp_rdata;
        end
        cpuReq = 1'b0; dmaReq = 1'b0;
      end
    end
    chk($sformatf("v%0d cpuRData", idx), cpuRData, exp_cpu_rd);
    chk($sformatf("v%0d dmaRData", idx), dmaRData, exp_dma_rd);
  endtask

  initial begin
    bit rr;
`ifdef MEM_ARB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    notReset = 1'b0;
    cpuReq = 0; cpuWrite = 0; cpuAddr = 0; cpuWData = 0;
    dmaReq = 0; dmaWrite = 0; dmaAddr = 0; dmaWData = 0;
    w3_cpuReq = 0; w3_cpuAddr = 0;
    load_en = 0; load_addr = 0; load_data = 0;
    exp_cpu_rd = 16'h0000; exp_dma_rd = 16'h0000;

    //           dma  wr   addr      wdata     exp_rdata
    vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    vecs[1] = '{1'b1, 1'b1, 16'h0020, 16'h1234, 16'h0000};
    vecs[2] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'h1234};
    vecs[3] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    vecs[4] = '{1'b0, 1'b1, 16'h0030, 16'hCAFE, 16'h0000};
    vecs[5] = '{1'b1, 1'b0, 16'h0030, 16'h0000, 16'hCAFE};

    load(8'h10, 16'hBEEF);
    load(8'h00, 16'hA0A0);
    load(8'h01, 16'h5151);

    @(negedge clock);
    chk("reset notCS", memNotCS, 1'b1);
    chk("reset notOE", memNotOE, 1'b1);
    chk("reset notWE", memNotWE, 1'b1);
    chk("reset dataOE", memDataOE, 1'b0);
    chk("reset memAddr", memAddr, 16'h0000);
    chk("reset cpuRData", cpuRData, 16'h0000);
    chk("reset grantDma", grantDma, 1'b0);
    notReset = 1'b1;

    for (int i = 0; i < 6; i++) run_txn(i, vecs[i]);

    // Reset asserted in the middle of a write strobe
    @(posedge clock); #1;
    cpuReq = 1'b1; cpuWrite = 1'b1; cpuAddr = 16'h0040; cpuWData = 16'h7777;
    repeat (3) @(negedge clock);
    chk("rst pre notWE", memNotWE, 1'b0);
    #2 notReset = 1'b0;
    #1;
    chk("rst notWE", memNotWE, 1'b1);
    chk("rst notCS", memNotCS, 1'b1);
    chk("rst notOE", memNotOE, 1'b1);
    chk("rst dataOE", memDataOE, 1'b0);
    chk("rst memAddr", memAddr, 16'h0000);
    chk("rst memWData", memWData, 16'h0000);
    chk("rst cpuAck", cpuAck, 1'b0);
    chk("rst cpuRData", cpuRData, 16'h0000);
    chk("rst dmaRData", dmaRData, 16'h0000);
    cpuReq = 1'b0;
    @(negedge clock);
    notReset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      chk($sformatf("post-rst c%0d cpuAck", c), cpuAck, 1'b0);
      chk($sformatf("post-rst c%0d notCS", c), memNotCS, 1'b1);
    end

    // Simultaneous requests, both held across two transactions
    @(posedge clock); #1;
    cpuReq = 1'b1; cpuWrite = 1'b0; cpuAddr = 16'h0000;
    dmaReq = 1'b1; dmaWrite = 1'b0; dmaAddr = 16'h0001;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clock);
      chk($sformatf("tie c%0d cpuAck", c), cpuAck, c == 3 || (!rr && c == 7));
      chk($sformatf("tie c%0d dmaAck", c), dmaAck, rr && c == 7);
      chk($sformatf("tie c%0d grantDma", c), grantDma, rr && c >= 5 && c <= 7);
      if (c == 3) chk("tie cpuRData 1", cpuRData, 16'hA0A0);
      if (c == 7) begin
        if (rr) chk("tie dmaRData", dmaRData, 16'h5151);
        else    chk("tie cpuRData 2", cpuRData, 16'hA0A0);
        cpuReq = 1'b0; dmaReq = 1'b0;
      end
    end

    // Back-to-back CPU reads with the request held across the ack
    @(posedge clock); #1;
    cpuReq = 1'b1; cpuWrite = 1'b0; cpuAddr = 16'h0000;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clock);
      chk($sformatf("b2b c%0d cpuAck", c), cpuAck, c == 3 || c == 7);
      if (c == 3) begin
        chk("b2b data 0", cpuRData, 16'hA0A0);
        cpuAddr = 16'h0001;
      end
      if (c == 5) chk("b2b memAddr", memAddr, 16'h0001);
      if (c == 7) begin
        chk("b2b data 1", cpuRData, 16'h5151);
        cpuReq = 1'b0;
      end
    end

    // Three-cycle strobe read on the second instance
    @(posedge clock); #1;
    w3_cpuReq = 1'b1; w3_cpuAddr = 16'h0010;
    for (int c = 0; c <= 7; c++) begin
      @(negedge clock);
      chk($sformatf("w3 c%0d notCS", c), w3_memNotCS, !(c >= 1 && c <= 5));
      chk($sformatf("w3 c%0d notOE", c), w3_memNotOE, !(c >= 2 && c <= 4));
      chk($sformatf("w3 c%0d notWE", c), w3_memNotWE, 1'b1);
      chk($sformatf("w3 c%0d cpuAck", c), w3_cpuAck, c == 5);
      if (c >= 1 && c <= 5) chk($sformatf("w3 c%0d memAddr", c), w3_memAddr, 16'h0010);
      if (c == 5) begin
        chk("w3 cpuRData", w3_cpuRData, 16'hBEEF);
        w3_cpuReq = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
